// File: rtl/odd_parity_checker_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared between the odd-parity generator and checker stages: default frame
// geometry and the frame-phase encoding used by both sides of the link.
// -----------------------------------------------------------------------------
package parity_pkg;

   // Default number of data bits per frame; a frame is DATA_BITS_DEF+1 bits.
   localparam int DATA_BITS_DEF = 3;

   // Default width of the saturating parity-error counter.
   localparam int ERR_CNT_W_DEF = 8;

   // Frame phase: collecting data bits, or expecting the parity bit next.
   typedef enum logic {
      DATA = 1'b0,
      PAR  = 1'b1
   } state_e;

endpackage : parity_pkg

// File: rtl/odd_parity_checker_if.sv
// -----------------------------------------------------------------------------
// odd_parity_checker_if
// Serial frame stream into the checker and its receive-side result/status.
//   in_valid   : ip carries a valid bit this cycle
//   ip         : serial bit (data MSB first, then parity)
//   sync       : drop any partial frame, next accepted bit is data MSB
//   data_out   : last completed frame's data word
//   out_valid  : one-cycle pulse per completed frame
//   parity_err : 1 = completed frame failed odd parity (qualified by out_valid)
//   err_count  : saturating count of failed frames
//   frame_busy : a partial frame is held
// Modports: master = bit source / result consumer, slave = the checker.
// -----------------------------------------------------------------------------
interface odd_parity_checker_if
   import parity_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int ERR_CNT_W = ERR_CNT_W_DEF
);

   logic                 in_valid;
   logic                 ip;
   logic                 sync;
   logic [DATA_BITS-1:0] data_out;
   logic                 out_valid;
   logic                 parity_err;
   logic [ERR_CNT_W-1:0] err_count;
   logic                 frame_busy;

   modport master (
      output in_valid, ip, sync,
      input  data_out, out_valid, parity_err, err_count, frame_busy
   );

   modport slave (
      input  in_valid, ip, sync,
      output data_out, out_valid, parity_err, err_count, frame_busy
   );

endinterface : odd_parity_checker_if

// File: rtl/odd_parity_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear
//   inc   : count up by one this cycle (ignored once saturated)
//   count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/odd_parity_checker.sv
// -----------------------------------------------------------------------------
// odd_parity_checker
// Reassembles serial frames of DATA_BITS data bits (MSB first) plus one
// odd-parity bit, reports the word with a per-frame error flag, and keeps a
// saturating count of failed frames.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of odd_parity_checker_if (bit stream in, results out)
// -----------------------------------------------------------------------------
module odd_parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
   input logic                 clk,
   input logic                 reset,
   odd_parity_checker_if.slave bus
);

   // Index has to reach DATA_BITS while the parity bit is pending.
   localparam int IDX_W = $clog2(DATA_BITS + 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q,   idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q,  data_d;
   logic                 perr_q,  perr_d;
   logic                 valid_q, valid_d;

   always_comb begin
      // NOTE: every signal driven here is given a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      perr_d  = perr_q;
      valid_d = 1'b0;

      // Realign first; a bit accepted in the same cycle then starts the new
      // frame as its data MSB, even if a parity bit was pending.
      if (bus.sync) begin
         state_d = DATA;
         idx_d   = '0;
         shift_d = '0;
      end

      if (bus.in_valid) begin
         unique case (state_d)
            DATA: begin
               shift_d = (shift_d << 1) | DATA_BITS'(bus.ip);
               if (idx_d == IDX_W'(DATA_BITS - 1)) begin
                  state_d = PAR;
               end
               idx_d = idx_d + IDX_W'(1);
            end
            PAR: begin
               data_d  = shift_d;
               // Odd parity: an even number of ones across word+parity is bad.
               perr_d  = ~(^{shift_d, bus.ip});
               valid_d = 1'b1;
               idx_d   = '0;
               state_d = DATA;
            end
            default: state_d = DATA;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= DATA;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         valid_q <= valid_d;
      end
   end

   // Counter advances on the same edge that raises out_valid for a bad frame.
   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (valid_d & perr_d),
      .count (bus.err_count)
   );

   assign bus.data_out   = data_q;
   assign bus.out_valid  = valid_q;
   assign bus.parity_err = perr_q;
   // Non-zero index means at least one data bit of a frame is held.
   assign bus.frame_busy = (idx_q != '0);

endmodule : odd_parity_checker
